hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage ARM pipeline. Compares ID-stage source
//  registers with EX/MEM/WB destinations and drives: the NOP-insert select on the control
//  unit output, PC and IF/ID load enables, IF/ID flush on taken branch, operand-forwarding
//  selects, and a whole-pipeline freeze while data memory is busy.
//  Sits beside the control unit in ID; all pipeline registers take their enables from it.
// PARAMETERS
//  HOLD_TIMEOUT  64  mem_wait cycles in HOLD before hold_err sets
//  STAT_W        16  width of saturating stall_count
// PORTS
//  clk          in   1  pipeline clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  id_rn        in   4  ID source Rn;  id_use_rn  in 1  Rn is read
//  id_rm        in   4  ID source Rm;  id_use_rm  in 1  Rm is read
//  id_rd        in   4  ID store-data reg;  id_use_rd in 1  Rd is read (STR)
//  ex_rd        in   4  EX dest;  ex_rf_en in 1;  ex_load in 1  (EX holds a load)
//  mem_rd       in   4  MEM dest; mem_rf_en in 1
//  wb_rd        in   4  WB dest;  wb_rf_en in 1
//  branch_taken in   1  ID branch resolved taken
//  mem_wait     in   1  data memory not ready
//  nop_sel      out  1  1 = control-unit NOP mux outputs all-zero control
//  pc_le        out  1  PC load enable
//  ifid_le      out  1  IF/ID load enable
//  ifid_flush   out  1  clear IF/ID on next edge
//  pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
//  fwd_a/b/c    out  2  each for Rn/Rm/Rd: 00 RF, 01 EX, 10 MEM, 11 WB
//  hold_err     out  1  sticky memory-timeout flag
//  stall_count  out  STAT_W  saturating count of stall cycles
// BEHAVIOUR
//  - match(x,s) = use_x & s_rf_en & (s_rd == x) & (x != 4'd15); R15 never matches.
//  - In reset: nop_sel=1, pc_le=0, ifid_le=0, ifid_flush=0, pipe_freeze=0, fwd_*=00,
//    hold_err=0, stall_count=0, state=RUN, hold_cnt=0.
//  - FSM states RUN, HOLD (registered).
//    RUN -> HOLD when mem_wait=1; HOLD -> RUN on first cycle with mem_wait=0.
//    HOLD: pipe_freeze=1, pc_le=0, ifid_le=0, nop_sel=0, ifid_flush=0; hold_cnt++.
//    hold_cnt==HOLD_TIMEOUT-1 while mem_wait=1 -> hold_err=1 (sticky until rst_n);
//    hold_cnt saturates, clears on exit to RUN.
//  - mem_wait is combinational into freeze: pipe_freeze=1 in the cycle mem_wait rises.
//  - RUN, stall = load-use (ex_load & match on any source vs EX) [or RAW, see CONFIG]:
//    nop_sel=1, pc_le=0, ifid_le=0, ifid_flush=0; combinational, same-cycle.
//    Load-use costs exactly 1 bubble; next cycle the load is in MEM and forwards.
//  - RUN, no stall: nop_sel=0, pc_le=1, ifid_le=1; ifid_flush=branch_taken.
//  - Priority: freeze > stall > flush. Branch in ID during stall is not flushed;
//    it is re-evaluated once the stall clears.
//  - Forward select priority per source: EX(01) > MEM(10) > WB(11) > RF(00);
//    load in EX is never forwarded (stall covers it).
//  - stall_count += 1 each stall cycle (not HOLD cycles); saturates at all-ones.
//  - Reset mid-HOLD or mid-stall: returns to reset values immediately.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding as above; only load-use stalls.
//  HAZARD_FWD_EN undefined: fwd_a/b/c tied 00; any match vs EX, MEM or WB stalls
//    (up to 3 bubbles per dependency); stall_count counts these too.
// TESTING
//  - Reset: rst_n=0 mid-cycle -> nop_sel=1, pc_le=0, stall_count=0 at once, async.
//  - EX: LDR R3, ID: ADD uses Rn=R3 -> 1 cycle nop_sel=1/pc_le=0, then fwd_a=10,
//    stall_count=1.
//  - EX/MEM/WB all write R5, ID reads Rm=R5 -> fwd_b=01; with only WB -> fwd_b=11;
//    ID reads R15 with EX writing R15 -> fwd=00, no stall.
//  - mem_wait=1 for 70 cycles -> pipe_freeze=1 throughout, hold_err=1 after 64,
//    stays 1 after mem_wait drops; stall_count unchanged.
//  - branch_taken=1 with no hazard -> ifid_flush=1 one cycle; with load-use hazard
//    same cycle -> ifid_flush=0, nop_sel=1.
//  - HAZARD_FWD_EN undefined, ADD R2 then dependent SUB on R2 -> 3 stall cycles,
//    fwd_* stay 00.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use and RAW stalls, operand forwarding,
// branch flush and data-memory freeze. Optional feature macro: HAZARD_FWD_EN enables forwarding.
module hazard_stall_ctrl #(
  parameter int unsigned HOLD_TIMEOUT = 64,
  parameter int unsigned STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        id_rn,
  input  logic              id_use_rn,
  input  logic [3:0]        id_rm,
  input  logic              id_use_rm,
  input  logic [3:0]        id_rd,
  input  logic              id_use_rd,
  input  logic [3:0]        ex_rd,
  input  logic              ex_rf_en,
  input  logic              ex_load,
  input  logic [3:0]        mem_rd,
  input  logic              mem_rf_en,
  input  logic [3:0]        wb_rd,
  input  logic              wb_rf_en,
  input  logic              branch_taken,
  input  logic              mem_wait,
  output logic              nop_sel,
  output logic              pc_le,
  output logic              ifid_le,
  output logic              ifid_flush,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_c,
  output logic              hold_err,
  output logic [STAT_W-1:0] stall_count
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam int unsigned HC_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOLD_TIMEOUT - 1);

  state_t            r_state;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_hold_err;
  logic [STAT_W-1:0] r_stall_cnt;

  logic [2:0] w_m_ex;
  logic [2:0] w_m_mem;
  logic [2:0] w_m_wb;
  logic       w_hazard;
  logic       w_freeze;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic [1:0] w_fwd_c;

  function automatic logic match(input logic use_x, input logic [3:0] x,
                                 input logic rf_en, input logic [3:0] rd);
    return use_x & rf_en & (rd == x) & (x != 4'd15);
  endfunction

  // Bit 0 = Rn, bit 1 = Rm, bit 2 = Rd (store data)
  assign w_m_ex  = {match(id_use_rd, id_rd, ex_rf_en,  ex_rd),
                    match(id_use_rm, id_rm, ex_rf_en,  ex_rd),
                    match(id_use_rn, id_rn, ex_rf_en,  ex_rd)};
  assign w_m_mem = {match(id_use_rd, id_rd, mem_rf_en, mem_rd),
                    match(id_use_rm, id_rm, mem_rf_en, mem_rd),
                    match(id_use_rn, id_rn, mem_rf_en, mem_rd)};
  assign w_m_wb  = {match(id_use_rd, id_rd, wb_rf_en,  wb_rd),
                    match(id_use_rm, id_rm, wb_rf_en,  wb_rd),
                    match(id_use_rn, id_rn, wb_rf_en,  wb_rd)};

`ifdef HAZARD_FWD_EN
  // A load still in EX has no data yet, so it falls through to older stages; the stall hides it.
  function automatic logic [1:0] fsel(input logic ex, input logic mem, input logic wb,
                                      input logic ld);
    if (ex && !ld)  return 2'b01;
    else if (mem)   return 2'b10;
    else if (wb)    return 2'b11;
    else            return 2'b00;
  endfunction

  assign w_hazard = ex_load & (|w_m_ex);
  assign w_fwd_a  = fsel(w_m_ex[0], w_m_mem[0], w_m_wb[0], ex_load);
  assign w_fwd_b  = fsel(w_m_ex[1], w_m_mem[1], w_m_wb[1], ex_load);
  assign w_fwd_c  = fsel(w_m_ex[2], w_m_mem[2], w_m_wb[2], ex_load);
`else
  // Without forwarding, load and non-load EX producers stall alike.
  assign w_hazard = ((|w_m_ex) & ex_load) | ((|w_m_ex) & ~ex_load) | (|w_m_mem) | (|w_m_wb);
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
  assign w_fwd_c  = 2'b00;
`endif

  assign w_freeze = mem_wait | (r_state == HOLD);
  assign w_stall  = ~w_freeze & w_hazard;

  always_comb begin
    nop_sel     = 1'b0;
    pc_le       = 1'b0;
    ifid_le     = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      nop_sel = 1'b1;
    end else if (w_freeze) begin
      pipe_freeze = 1'b1;
    end else if (w_stall) begin
      nop_sel = 1'b1;
    end else begin
      pc_le      = 1'b1;
      ifid_le    = 1'b1;
      ifid_flush = branch_taken;
    end
  end

  assign fwd_a       = rst_n ? w_fwd_a : 2'b00;
  assign fwd_b       = rst_n ? w_fwd_b : 2'b00;
  assign fwd_c       = rst_n ? w_fwd_c : 2'b00;
  assign hold_err    = r_hold_err;
  assign stall_count = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_hold_cnt  <= '0;
      r_hold_err  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        RUN: begin
          r_hold_cnt <= '0;
          if (mem_wait)
            r_state <= HOLD;
        end
        HOLD: begin
          if (!mem_wait) begin
            r_state    <= RUN;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HC_MAX) begin
            r_hold_err <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
